conv1d_mc_engine: RTL and testbench

Parametrised multi-channel 1D convolution engine, successor to the single-channel conv1d accelerator in the user domain. Fetches samples over an OBI-style memory master and applies a per-channel K-tap signed kernel (valid mode, no padding). Writes arithmetically shifted, saturated results back to memory and raises a sticky completion interrupt. Configuration comes from the conv1d control register file; the OBI/register wrapper instantiates this engine.

---
 rtl/conv1d_mc_engine.sv | 217 +++++++++++++++++++++
 tb/tb_conv1d_mc_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mc_engine.sv
// Multi-channel valid-mode 1D convolution engine. It reads samples and writes results through a memory master that keeps one transaction outstanding.
// Latency: a read takes 2 cycles, the MAC takes K cycles and a write takes 2 cycles, so steady state is K+4 cycles per output.
// Backpressure: request fields hold until mem_gnt_i, and every transaction waits for mem_rvalid_i before the next one is issued.
module conv1d_mc_engine #(
    parameter int NUM_CH   = 4,
    parameter int NUM_TAPS = 5,
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 8,
    parameter int LEN_W    = 12
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [31:0]                        src_addr_i,
    input  logic [31:0]                        dst_addr_i,
    input  logic [LEN_W-1:0]                   len_i,
    input  logic [4:0]                         shift_i,
    input  logic [NUM_CH*NUM_TAPS*COEFF_W-1:0] coeff_i,
    input  logic                               int_clr_i,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [31:0]                        mem_addr_o,
    output logic [31:0]                        mem_wdata_o,
    input  logic                               mem_gnt_i,
    input  logic                               mem_rvalid_i,
    input  logic [31:0]                        mem_rdata_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               done_int_o,
    output logic                               err_o
);
    localparam int ACC_W  = DATA_W + COEFF_W + $clog2(NUM_TAPS);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAP_W  = $clog2(NUM_TAPS);
    localparam int FILL_W = $clog2(NUM_TAPS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, MAC, WR_REQ, WR_WAIT, NEXT_CH, DONE
    } state_t;

    state_t                    state;
    logic [31:0]               rd_ptr;
    logic [31:0]               wr_ptr;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          rd_idx;
    logic [4:0]                shift_q;
    logic [CH_W-1:0]           ch_q;
    logic [TAP_W-1:0]          tap_q;
    logic [FILL_W-1:0]         fill_q;
    logic signed [COEFF_W-1:0] coef_q [NUM_CH][NUM_TAPS];
    logic signed [DATA_W-1:0]  win_q [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc_q;

    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   mac_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  result;
    logic signed [DATA_W-1:0]  sample;
    logic                      rdata_unused;

    assign sample       = mem_rdata_i[DATA_W-1:0];
    assign rdata_unused = ^mem_rdata_i;

    // The last MAC cycle writes the final sum, so the result is formed from mac_sum.
    always_comb begin
        prod    = ACC_W'(win_q[tap_q]) * ACC_W'(coef_q[ch_q][tap_q]);
        mac_sum = acc_q + prod;
        shifted = mac_sum >>> shift_q;
        result  = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            done_int_o  <= 1'b0;
            err_o       <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            len_q       <= '0;
            rd_idx      <= '0;
            shift_q     <= '0;
            ch_q        <= '0;
            tap_q       <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < NUM_TAPS; k++) coef_q[c][k] <= '0;
        end else begin
            done_o <= 1'b0;
            if (int_clr_i) begin
                done_int_o <= 1'b0;
                err_o      <= 1'b0;
            end
            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i && !busy_o) begin
                        busy_o  <= 1'b1;
                        len_q   <= len_i;
                        shift_q <= shift_i;
                        wr_ptr  <= dst_addr_i;
                        ch_q    <= '0;
                        rd_idx  <= '0;
                        fill_q  <= '0;
                        acc_q   <= '0;
                        for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= '0;
                        for (int c = 0; c < NUM_CH; c++)
                            for (int k = 0; k < NUM_TAPS; k++)
                                coef_q[c][k] <= coeff_i[(c*NUM_TAPS+k)*COEFF_W +: COEFF_W];
                        if (len_i < LEN_W'(NUM_TAPS)) begin
                            err_o <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= src_addr_i;
                            rd_ptr     <= src_addr_i + 32'd4;
                            state      <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        for (int k = 0; k < NUM_TAPS-1; k++) win_q[k] <= win_q[k+1];
                        win_q[NUM_TAPS-1] <= sample;
                        rd_idx <= rd_idx + LEN_W'(1);
                        if (fill_q != FILL_W'(NUM_TAPS)) fill_q <= fill_q + FILL_W'(1);
                        if (fill_q >= FILL_W'(NUM_TAPS-1)) begin
                            acc_q <= '0;
                            tap_q <= '0;
                            state <= MAC;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= rd_ptr;
                            rd_ptr     <= rd_ptr + 32'd4;
                            state      <= RD_REQ;
                        end
                    end
                end
                MAC: begin
                    acc_q <= mac_sum;
                    if (tap_q == TAP_W'(NUM_TAPS-1)) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= wr_ptr;
                        mem_wdata_o <= 32'(result);
                        wr_ptr      <= wr_ptr + 32'd4;
                        state       <= WR_REQ;
                    end else begin
                        tap_q <= tap_q + TAP_W'(1);
                    end
                end
                WR_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (rd_idx == len_q) begin
                            state <= NEXT_CH;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= rd_ptr;
                            rd_ptr     <= rd_ptr + 32'd4;
                            state      <= RD_REQ;
                        end
                    end
                end
                NEXT_CH: begin
                    if (ch_q == CH_W'(NUM_CH-1)) begin
                        state <= DONE;
                    end else begin
                        // Channels are contiguous in memory, so rd_ptr already points at the next channel.
                        ch_q   <= ch_q + CH_W'(1);
                        rd_idx <= '0;
                        fill_q <= '0;
                        for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= '0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= rd_ptr;
                        rd_ptr     <= rd_ptr + 32'd4;
                        state      <= RD_REQ;
                    end
                end
                DONE: begin
                    done_o     <= 1'b1;
                    done_int_o <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_mc_engine.sv
// Directed, table-driven bench for conv1d_mc_engine.
// A memory slave with programmable grant and response delays sits behind the engine and logs every write.
module tb_conv1d_mc_engine;
    localparam int NUM_CH = 4, NUM_TAPS = 5, DATA_W = 16, COEFF_W = 8, LEN_W = 12;
    localparam int CW = NUM_CH*NUM_TAPS*COEFF_W;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [31:0]       src_addr_i = '0;
    logic [31:0]       dst_addr_i = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic [4:0]        shift_i = '0;
    logic [CW-1:0]     coeff_i = '0;
    logic              int_clr_i = 1'b0;
    logic              mem_req_o, mem_we_o;
    logic [31:0]       mem_addr_o, mem_wdata_o;
    logic              mem_gnt_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;
    logic              busy_o, done_o, done_int_o, err_o;

    conv1d_mc_engine #(.NUM_CH(NUM_CH), .NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W),
                       .COEFF_W(COEFF_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .shift_i(shift_i), .coeff_i(coeff_i), .int_clr_i(int_clr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o),
        .done_int_o(done_int_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          len;
        int          shift;
        int          pat;
        logic [31:0] src;
        logic [31:0] dst;
        logic [CW-1:0] coeff;
        int          gd;
        int          rd;
        int          nexp;
        bit          err;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_tab [7][16];
    logic [31:0] mem [1024];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          checks = 0, errors = 0;
    int          gnt_dly = 0, rv_dly = 0, g_wait = 0, r_wait = 0;
    int          grant_cnt = 0, viol = 0, done_cnt = 0, rv_tot = 0;
    bit          pend = 0, hold_vld = 0;
    logic [31:0] pend_dat = '0, h_addr = '0, h_wdata = '0;
    logic        h_we = 1'b0;

    function automatic logic [39:0] kern(input int t0, input int t1, input int t2,
                                         input int t3, input int t4);
        return {8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    function automatic logic [31:0] pat_word(input int pat, input int w);
        case (pat)
            0:       return {16'hA5A5, 16'(w + 1)};
            1:       return 32'h12347FFF;
            default: return 32'h00008000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory slave: grant after gnt_dly waiting cycles, respond rv_dly cycles after the nominal slot.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                mem_gnt_i = 0; mem_rvalid_i = 0; pend = 0; g_wait = 0; hold_vld = 0;
            end else begin
                mem_rvalid_i = 0;
                if (done_o) done_cnt++;
                if (mem_gnt_i) begin
                    mem_gnt_i = 0; pend = 1; r_wait = rv_dly;
                end
                if (pend) begin
                    if (mem_req_o) viol++;
                    if (r_wait == 0) begin
                        mem_rvalid_i = 1; mem_rdata_i = pend_dat; pend = 0; rv_tot++;
                    end else begin
                        r_wait--;
                    end
                end else if (mem_req_o) begin
                    if (hold_vld && (mem_addr_o !== h_addr || mem_we_o !== h_we ||
                                     (h_we && mem_wdata_o !== h_wdata))) viol++;
                    if (g_wait < gnt_dly) begin
                        g_wait++; hold_vld = 1;
                        h_addr = mem_addr_o; h_we = mem_we_o; h_wdata = mem_wdata_o;
                    end else begin
                        mem_gnt_i = 1; g_wait = 0; hold_vld = 0; grant_cnt++;
                        if (mem_we_o) begin
                            wr_addr_q.push_back(mem_addr_o);
                            wr_data_q.push_back(mem_wdata_o);
                            pend_dat = '0;
                        end else begin
                            pend_dat = mem[mem_addr_o[11:2]];
                        end
                    end
                end
            end
        end
    end

    task automatic apply_cfg(input int v);
        for (int w = 0; w < NUM_CH*vecs[v].len; w++)
            mem[vecs[v].src[11:2] + 10'(w)] = pat_word(vecs[v].pat, w);
        src_addr_i = vecs[v].src;
        dst_addr_i = vecs[v].dst;
        len_i      = LEN_W'(vecs[v].len);
        shift_i    = 5'(vecs[v].shift);
        coeff_i    = vecs[v].coeff;
        gnt_dly    = vecs[v].gd;
        rv_dly     = vecs[v].rd;
    endtask

    task automatic run_vec(input int v, input bit hold_clr);
        vec_t t;
        bit   seen;
        int   nout, idx;
        t = vecs[v];
        wr_addr_q.delete(); wr_data_q.delete();
        grant_cnt = 0; viol = 0; done_cnt = 0; seen = 0;
        @(negedge clk_i);
        apply_cfg(v);
        int_clr_i = hold_clr;
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        chk($sformatf("v%0d_busy_start", v), busy_o, 1);
        if (!t.err) begin
            // A second start with different configuration while busy must change nothing.
            repeat (5) @(negedge clk_i);
            src_addr_i = 32'h300; dst_addr_i = 32'h900; len_i = 7; shift_i = 3; coeff_i = '0;
            start_i = 1;
            @(negedge clk_i);
            start_i = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        chk($sformatf("v%0d_done_seen", v), seen, 1);
        chk($sformatf("v%0d_done_int_at_done", v), done_int_o, 1);
        chk($sformatf("v%0d_err_at_done", v), err_o, t.err);
        @(negedge clk_i);
        chk($sformatf("v%0d_busy_after", v), busy_o, 0);
        repeat (2) @(negedge clk_i);
        chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
        chk($sformatf("v%0d_done_int_sticky", v), done_int_o, !hold_clr);
        chk($sformatf("v%0d_err_sticky", v), err_o, t.err && !hold_clr);
        int_clr_i = 1;
        @(negedge clk_i);
        int_clr_i = 0;
        chk($sformatf("v%0d_done_int_clr", v), done_int_o, 0);
        chk($sformatf("v%0d_err_clr", v), err_o, 0);
        chk($sformatf("v%0d_grants", v), grant_cnt, t.err ? 0 : NUM_CH*t.len + t.nexp);
        chk($sformatf("v%0d_protocol", v), viol, 0);
        chk($sformatf("v%0d_nwrites", v), wr_data_q.size(), t.nexp);
        nout = t.len - NUM_TAPS + 1;
        if (!t.err) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int j = 0; j < nout; j++) begin
                    idx = c*nout + j;
                    if (idx < wr_data_q.size()) begin
                        chk($sformatf("v%0d_addr%0d", v, idx), wr_addr_q[idx], t.dst + 32'(4*idx));
                        chk($sformatf("v%0d_data%0d", v, idx), wr_data_q[idx], exp_tab[v][idx]);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len:8, shift:0, pat:0, src:32'h100, dst:32'h800, gd:0, rd:0, nexp:16, err:0,
                    coeff:{kern(0,0,0,0,1), kern(0,0,0,0,1), kern(0,0,0,0,1), kern(1,2,1,0,0)}};
        exp_tab[0] = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd13, 32'd14, 32'd15, 32'd16,
                       32'd21, 32'd22, 32'd23, 32'd24, 32'd29, 32'd30, 32'd31, 32'd32};
        vecs[1] = '{len:5, shift:0, pat:1, src:32'h200, dst:32'h840, gd:0, rd:0, nexp:4, err:0,
                    coeff:{4{kern(127,127,127,127,127)}}};
        exp_tab[1] = '{4{32'h00007FFF}, 12{32'h0}};
        vecs[2] = '{len:5, shift:0, pat:2, src:32'h200, dst:32'h880, gd:0, rd:0, nexp:4, err:0,
                    coeff:{4{kern(127,127,127,127,127)}}};
        exp_tab[2] = '{4{32'hFFFF8000}, 12{32'h0}};
        vecs[3] = '{len:5, shift:1, pat:0, src:32'h100, dst:32'h8C0, gd:0, rd:0, nexp:4, err:0,
                    coeff:{kern(0,0,0,0,0), kern(1,1,0,0,0), kern(0,0,0,0,-1), kern(-5,0,0,0,0)}};
        exp_tab[3] = '{32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0000000B, 32'h0, 12{32'h0}};
        vecs[4] = '{len:6, shift:2, pat:0, src:32'h100, dst:32'hA00, gd:0, rd:0, nexp:8, err:0,
                    coeff:{kern(0,0,3,0,0), kern(2,0,0,0,0), kern(1,0,0,0,-1), kern(1,1,1,1,1)}};
        exp_tab[4] = '{32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6, 32'd7, 32'd15, 32'd16,
                       8{32'h0}};
        vecs[5] = vecs[4];
        vecs[5].gd = 3; vecs[5].rd = 2; vecs[5].dst = 32'hB00;
        exp_tab[5] = exp_tab[4];
        vecs[6] = '{len:3, shift:0, pat:0, src:32'h100, dst:32'hC00, gd:0, rd:0, nexp:0, err:1,
                    coeff:{4{kern(1,1,1,1,1)}}};
        exp_tab[6] = '{16{32'h0}};

        repeat (3) @(negedge clk_i);
        chk("reset_outputs", {mem_req_o, mem_we_o, busy_o, done_o, done_int_o, err_o,
                              |mem_addr_o, |mem_wdata_o}, 0);
        rst_ni = 1;
        repeat (2) @(negedge clk_i);

        for (int v = 0; v < 7; v++) run_vec(v, 1'b0);

        // Set of done_int_o must win over an int_clr_i held across the done cycle.
        run_vec(4, 1'b1);

        // Asynchronous reset during MAC, then a clean run.
        @(negedge clk_i);
        apply_cfg(0);
        rv_tot = 0;
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk_i);
            #1;
            if (rv_tot >= 5) break;
        end
        chk("rst_reached_mac", rv_tot, 5);
        chk("rst_busy_before", busy_o, 1);
        rst_ni = 0;
        #1;
        chk("rst_mid_outputs", {mem_req_o, mem_we_o, busy_o, done_o, done_int_o, err_o,
                                |mem_addr_o, |mem_wdata_o}, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1;
        grant_cnt = 0;
        repeat (4) @(negedge clk_i);
        chk("rst_no_req_after", {mem_req_o, busy_o}, 0);
        chk("rst_no_grants_after", grant_cnt, 0);
        run_vec(4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
